// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-I subset core: encodings,
// ALU operation set, memory geometry and the combinational ALU.
package cpu_pkg;

  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = 10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  // Shifts operate on b (the rt value); add/sub wrap with no overflow trap.
  function automatic logic [31:0] alu_compute(alu_op_t op, logic [31:0] a,
                                              logic [31:0] b, logic [4:0] sh,
                                              logic [15:0] imm);
    logic [31:0] res;
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_NOR:  res = ~(a | b);
      ALU_SLT:  res = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: res = {31'b0, a < b};
      ALU_SLL:  res = b << sh;
      ALU_SRL:  res = b >> sh;
      ALU_SRA:  res = $unsigned($signed(b) >>> sh);
      ALU_LUI:  res = {imm, 16'h0000};
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32 x 32 register file: two combinational reads, one synchronous write,
// $0 hardwired to zero, synchronous clear on reset.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] reg_file [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) reg_file[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      reg_file[wr_addr] <= wr_data;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  assign rs_data = (rs_addr == 5'd0) ? '0 : reg_file[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? '0 : reg_file[rt_addr];

endmodule

// File: rtl/cpu_top.sv
// Single-cycle MIPS-I subset core: one instruction committed per clock,
// private word-addressed instruction and data memories.
module cpu_top
  import cpu_pkg::*;
(
  input logic clk,
  input logic reset
);

  logic [31:0] imem [0:MEM_DEPTH-1];
  logic [31:0] dmem [0:MEM_DEPTH-1];

  logic [31:0] curr_pc_top, next_pc, pc_plus4;
  logic [31:0] instr_top;
  logic [4:0]  rs_top, rt_top, rd_top, shamt, wr_addr;
  logic [5:0]  opcode, funct;
  logic [15:0] imm16;
  logic [31:0] sext_imm, zext_imm, branch_target, jump_target;
  logic [31:0] rs_data, rt_data, alu_b, alu_result, load_data;
  logic [31:0] wr_data_rf_top;
  logic        reg_wr_top, is_r_type_top, is_i_type_top;
  logic        use_imm, zero_ext, is_load, is_link, mem_wr;
  alu_op_t     alu_op;

  assign instr_top = imem[curr_pc_top[MEM_AW+1:2]];
  assign opcode    = instr_top[31:26];
  assign rs_top    = instr_top[25:21];
  assign rt_top    = instr_top[20:16];
  assign rd_top    = instr_top[15:11];
  assign shamt     = instr_top[10:6];
  assign funct     = instr_top[5:0];
  assign imm16     = instr_top[15:0];

  assign sext_imm      = {{16{imm16[15]}}, imm16};
  assign zext_imm      = {16'h0000, imm16};
  assign pc_plus4      = curr_pc_top + 32'd4;
  assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr_top[25:0], 2'b00};

  cpu_regfile R1 (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs_top),
    .rt_addr (rt_top),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wr_en   (reg_wr_top),
    .wr_addr (wr_addr),
    .wr_data (wr_data_rf_top)
  );

  // NOTE: every output of this block gets a default first; otherwise any
  // opcode path that skips an assignment would infer a latch.
  always_comb begin
    alu_op        = ALU_ADD;
    use_imm       = 1'b0;
    zero_ext      = 1'b0;
    is_load       = 1'b0;
    is_link       = 1'b0;
    mem_wr        = 1'b0;
    reg_wr_top    = 1'b0;
    wr_addr       = rt_top;
    next_pc       = pc_plus4;
    is_r_type_top = 1'b0;
    is_i_type_top = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_r_type_top = 1'b1;
        wr_addr       = rd_top;
        reg_wr_top    = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
          FN_JR: begin
            reg_wr_top = 1'b0;
            next_pc    = rs_data;
          end
          default:         reg_wr_top = 1'b0;  // syscall and unknown functs
        endcase
      end
      OP_J:   next_pc = jump_target;
      OP_JAL: begin
        next_pc    = jump_target;
        reg_wr_top = 1'b1;
        wr_addr    = 5'd31;
        is_link    = 1'b1;
      end
      OP_BEQ: begin
        is_i_type_top = 1'b1;
        if (rs_data == rt_data) next_pc = branch_target;
      end
      OP_BNE: begin
        is_i_type_top = 1'b1;
        if (rs_data != rt_data) next_pc = branch_target;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        is_i_type_top = 1'b1;
        use_imm       = 1'b1;
        reg_wr_top    = 1'b1;
        case (opcode)
          OP_SLTI:  alu_op = ALU_SLT;
          OP_SLTIU: alu_op = ALU_SLTU;
          OP_ANDI:  begin alu_op = ALU_AND; zero_ext = 1'b1; end
          OP_ORI:   begin alu_op = ALU_OR;  zero_ext = 1'b1; end
          OP_XORI:  begin alu_op = ALU_XOR; zero_ext = 1'b1; end
          OP_LUI:   alu_op = ALU_LUI;
          default:  alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        is_i_type_top = 1'b1;
        use_imm       = 1'b1;
        is_load       = 1'b1;
        reg_wr_top    = 1'b1;
      end
      OP_SW: begin
        is_i_type_top = 1'b1;
        use_imm       = 1'b1;
        mem_wr        = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_b      = use_imm ? (zero_ext ? zext_imm : sext_imm) : rt_data;
  assign alu_result = alu_compute(alu_op, rs_data, alu_b, shamt, imm16);
  assign load_data  = dmem[alu_result[MEM_AW+1:2]];

  assign wr_data_rf_top = is_link ? pc_plus4 :
                          is_load ? load_data : alu_result;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) curr_pc_top <= '0;
    else       curr_pc_top <= next_pc;
  end

  // NOTE: dmem has no reset; its contents survive a reset by design and a
  // clear loop would also prevent mapping it onto RAM.
  always_ff @(posedge clk) begin
    if (!reset && mem_wr) dmem[alu_result[MEM_AW+1:2]] <= rt_data;
  end

endmodule

// File: tb/tb_cpu_top.sv
// Lock-step bench for cpu_top: directed program plus a random program,
// both checked against an instruction-level reference model.
module tb_cpu_top;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  cpu_top dut (.clk(clk), .reset(reset));

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] b_imem [0:1023];
  logic [31:0] m_mem  [0:1023];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(logic [5:0] op, logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  // Architectural effect of one instruction, straight from the ISA rules.
  task automatic model_exec(input logic [31:0] ins, output logic wr, output logic [4:0] wa,
                            output logic [31:0] wd, output logic mw, output logic [9:0] ma,
                            output logic [31:0] md, output logic [31:0] npc);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, se, ze, ea;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a  = m_regs[rs]; b = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    ea = a + se;
    wr = 1'b0; wa = rt; wd = '0; mw = 1'b0; ma = ea[11:2]; md = b;
    npc = m_pc + 32'd4;
    case (op)
      6'h00: begin
        wa = rd; wr = 1'b1;
        case (fn)
          6'h20, 6'h21: wd = a + b;
          6'h22, 6'h23: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h26: wd = a ^ b;
          6'h27: wd = ~(a | b);
          6'h2A: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: wd = (a < b) ? 32'd1 : 32'd0;
          6'h00: wd = b << sh;
          6'h02: wd = b >> sh;
          6'h03: wd = $unsigned($signed(b) >>> sh);
          6'h08: begin wr = 1'b0; npc = a; end
          default: wr = 1'b0;
        endcase
      end
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        wr = 1'b1; wa = 5'd31; wd = npc;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      6'h04: if (a == b) npc = npc + (se << 2);
      6'h05: if (a != b) npc = npc + (se << 2);
      6'h08, 6'h09: begin wr = 1'b1; wd = a + se; end
      6'h0A: begin wr = 1'b1; wd = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0B: begin wr = 1'b1; wd = (a < se) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; wd = a & ze; end
      6'h0D: begin wr = 1'b1; wd = a | ze; end
      6'h0E: begin wr = 1'b1; wd = a ^ ze; end
      6'h0F: begin wr = 1'b1; wd = {ins[15:0], 16'h0}; end
      6'h23: begin wr = 1'b1; wd = m_mem[ea[11:2]]; end
      6'h2B: mw = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  // Called at a falling edge: compare the current cycle, commit it in the
  // model, then advance to the next falling edge.
  task automatic run_lockstep(input int n);
    logic [31:0] ins, wd, md, npc;
    logic        wr, mw;
    logic [4:0]  wa;
    logic [9:0]  ma;
    for (int c = 0; c < n; c++) begin
      ins = b_imem[m_pc[11:2]];
      model_exec(ins, wr, wa, wd, mw, ma, md, npc);
      check("pc", dut.curr_pc_top, m_pc);
      check("instr", dut.instr_top, ins);
      check("reg_wr", {31'b0, dut.reg_wr_top}, {31'b0, wr});
      check("is_r_type", {31'b0, dut.is_r_type_top}, {31'b0, ins[31:26] == 6'h00});
      if (wr) begin
        check("wr_data", dut.wr_data_rf_top, wd);
        check("rd_or_rt", {27'b0, ins[31:26] == 6'h00 ? dut.rd_top : dut.rt_top},
              {27'b0, ins[31:26] == 6'h00 ? ins[15:11] : ins[20:16]});
      end
      if (wr && wa != 5'd0) m_regs[wa] = wd;
      if (mw) m_mem[ma] = md;
      m_pc = npc;
      @(negedge clk);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, dut.curr_pc_top, m_pc);
    for (int i = 0; i < 32; i++) check({tag, "_reg"}, dut.R1.reg_file[i], m_regs[i]);
  endtask

  task automatic load_imem();
    for (int i = 0; i < 1024; i++) dut.imem[i] = b_imem[i];
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [31:0] ins;
    rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
    rd = 5'($urandom_range(0, 31)); sh = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    case ($urandom_range(0, 8))
      0, 1: begin
        case ($urandom_range(0, 9))
          0: ins = r_ins(6'h20, rs, rt, rd, 5'd0);
          1: ins = r_ins(6'h21, rs, rt, rd, 5'd0);
          2: ins = r_ins(6'h22, rs, rt, rd, 5'd0);
          3: ins = r_ins(6'h23, rs, rt, rd, 5'd0);
          4: ins = r_ins(6'h24, rs, rt, rd, 5'd0);
          5: ins = r_ins(6'h25, rs, rt, rd, 5'd0);
          6: ins = r_ins(6'h26, rs, rt, rd, 5'd0);
          7: ins = r_ins(6'h27, rs, rt, rd, 5'd0);
          8: ins = r_ins(6'h2A, rs, rt, rd, 5'd0);
          default: ins = r_ins(6'h2B, rs, rt, rd, 5'd0);
        endcase
      end
      2: ins = r_ins(6'($urandom_range(0, 1) ? 6'h03 : ($urandom_range(0, 1) ? 6'h02 : 6'h00)),
                     5'd0, rt, rd, sh);
      3: ins = i_ins(6'($urandom_range(8, 15)), rs, rt, imm);
      4: ins = i_ins(6'h09, 5'd0, rt, imm);
      5: ins = i_ins(6'h23, rs, rt, imm);
      6: ins = i_ins(6'h2B, rs, rt, imm);
      7: ins = i_ins(6'($urandom_range(4, 5)), rs, rt, 16'($urandom_range(0, 3)));
      default: ins = $urandom_range(0, 1) ? 32'h0000_000C : {6'h3F, 26'($urandom)};
    endcase
    return ins;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      b_imem[i] = '0;
      m_mem[i]  = $urandom;
      dut.dmem[i] = m_mem[i];
    end
    b_imem['h00 >> 2] = i_ins(6'h09, 5'd0, 5'd8, 16'd5);
    b_imem['h04 >> 2] = i_ins(6'h09, 5'd0, 5'd9, 16'hFFFD);
    b_imem['h08 >> 2] = r_ins(6'h21, 5'd8, 5'd9, 5'd10, 5'd0);
    b_imem['h0C >> 2] = i_ins(6'h0F, 5'd0, 5'd1, 16'h1234);
    b_imem['h10 >> 2] = i_ins(6'h04, 5'd0, 5'd0, 16'd2);
    b_imem['h14 >> 2] = i_ins(6'h09, 5'd0, 5'd20, 16'd99);
    b_imem['h18 >> 2] = i_ins(6'h09, 5'd0, 5'd20, 16'd98);
    b_imem['h1C >> 2] = i_ins(6'h05, 5'd0, 5'd0, 16'd5);
    b_imem['h20 >> 2] = j_ins(6'h03, 32'h40);
    b_imem['h24 >> 2] = i_ins(6'h0D, 5'd1, 5'd1, 16'h5678);
    b_imem['h28 >> 2] = i_ins(6'h2B, 5'd0, 5'd1, 16'd8);
    b_imem['h2C >> 2] = i_ins(6'h23, 5'd0, 5'd2, 16'd8);
    b_imem['h30 >> 2] = i_ins(6'h09, 5'd0, 5'd0, 16'd7);
    b_imem['h34 >> 2] = i_ins(6'h0F, 5'd0, 5'd3, 16'h8000);
    b_imem['h38 >> 2] = r_ins(6'h03, 5'd0, 5'd3, 5'd4, 5'd4);
    b_imem['h3C >> 2] = j_ins(6'h02, 32'h50);
    b_imem['h40 >> 2] = r_ins(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
    b_imem['h50 >> 2] = i_ins(6'h09, 5'd0, 5'd5, 16'hFFFF);
    b_imem['h54 >> 2] = i_ins(6'h09, 5'd0, 5'd6, 16'd1);
    b_imem['h58 >> 2] = r_ins(6'h2A, 5'd5, 5'd6, 5'd7, 5'd0);
    b_imem['h5C >> 2] = r_ins(6'h2B, 5'd5, 5'd6, 5'd11, 5'd0);
    b_imem['h60 >> 2] = i_ins(6'h09, 5'd0, 5'd2, 16'd10);
    b_imem['h64 >> 2] = 32'h0000_000C;
    load_imem();

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_state("reset");
    reset = 1'b0;
    run_lockstep(21);

    check("end_pc", dut.curr_pc_top, 32'h68);
    check("r10_sum", dut.R1.reg_file[10], 32'd2);
    check("r20_skipped", dut.R1.reg_file[20], 32'd0);
    check("r31_link", dut.R1.reg_file[31], 32'h24);
    check("r1_luiori", dut.R1.reg_file[1], 32'h1234_5678);
    check("dmem2", dut.dmem[2], 32'h1234_5678);
    check("r0_zero", dut.R1.reg_file[0], 32'd0);
    check("r4_sra", dut.R1.reg_file[4], 32'hF800_0000);
    check("r7_slt", dut.R1.reg_file[7], 32'd1);
    check("r11_sltu", dut.R1.reg_file[11], 32'd0);
    check("r2_addiu", dut.R1.reg_file[2], 32'd10);

    reset = 1'b1;
    for (int i = 0; i < 1024; i++) b_imem[i] = (i < 64) ? rand_instr() : 32'h0;
    load_imem();
    @(negedge clk);
    model_reset();
    check_state("reload");
    reset = 1'b0;
    run_lockstep(80);
    check_state("random_end");

    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_state("mid_reset");
    for (int i = 0; i < 1024; i++) check("dmem_kept", dut.dmem[i], m_mem[i]);
    reset = 1'b0;
    run_lockstep(12);
    check_state("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
# cpu_top

Single-cycle 32-bit MIPS-I subset processor core with private instruction and data memories. Top of the CPU hierarchy; executes exactly one instruction per clock and exposes architectural state through fixed-name internal nets for lock-step comparison against a golden ISA model.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- No other ports; memories are internal arrays preloaded hierarchically before reset release.

## Operation
- Fetch: instr_top = imem[curr_pc_top[11:2]]; imem and dmem each 1024 x 32, word-addressed; upper address bits ignored.
- Decode fields: rs_top = instr[25:21], rt_top = instr[20:16], rd_top = instr[15:11], shamt = instr[10:6], imm16 = instr[15:0].
- is_r_type_top = 1 when opcode 0x00; is_i_type_top = 1 for all supported opcodes except 0x00, 0x02, 0x03.
- R-type (funct): add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, jr 0x08, syscall 0x0C; write rd (except jr, syscall).
- I-type: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B (sign-ext imm), andi 0x0C, ori 0x0D, xori 0x0E (zero-ext imm), lui 0x0F (imm<<16), lw 0x23, sw 0x2B, beq 0x04, bne 0x05; ALU/lw write rt.
- J-type: j 0x02, jal 0x03 (jal writes PC+4 to $31).
- add/sub/addi wrap modulo 2^32; no overflow trap.
- Branch target = PC+4 + (sext(imm16)<<2); jump target = {PC+4[31:28], instr[25:0], 2'b00}; jr target = rs value. No delay slot.
- syscall, unsupported opcodes/functs: no register/memory write, PC+4.
- reg_wr_top = 1 when the current instruction writes a register; wr_data_rf_top = value written that edge (ALU result, load data, or link address).
- Writes to $0 are discarded; $0 always reads 0.
- lw/sw address = rs + sext(imm16), word aligned (addr[1:0] ignored).

## Timing
- Reset (synchronous): curr_pc_top <= 0x0000_0000; all 32 registers <= 0; memories untouched.
- Every non-reset rising edge: commit exactly one instruction (PC, register, dmem write).
- Register file: two combinational reads, one synchronous write; read-during-write returns old value.
- dmem: combinational read, synchronous write.
- Observation nets are combinational from current PC/instruction and stable by the falling edge.
- Reset asserted mid-program: next edge restores PC 0 and zero registers; dmem keeps contents.

## Structure
- Package cpu_pkg: opcode and funct constants, ALU-op enum, memory depth constant.
- Sub-module register file instantiated as R1 with array reg_file[0:31].
- Nets curr_pc_top, instr_top, rs_top, rt_top, rd_top, reg_wr_top, wr_data_rf_top, is_r_type_top, is_i_type_top exist with exactly these names in cpu_top.
- Memories named imem and dmem for hierarchical preload.

## Test plan
- Reset then addiu $8,$0,5; addiu $9,$0,-3; addu $10,$8,$9 -> $10 = 2, reg_wr_top each cycle, PC 0,4,8,C.
- lui $1,0x1234; ori $1,$1,0x5678; sw $1,8($0); lw $2,8($0) -> $2 = 0x12345678, dmem[2] = 0x12345678.
- beq $0,$0,+2 at PC 0x10 -> next PC 0x1C; bne $0,$0 -> PC+4.
- jal at PC 0x20 to 0x40 -> $31 = 0x24, PC 0x40; jr $31 -> PC 0x24.
- addiu $0,$0,7 -> $0 stays 0; sra of 0x80000000 by 4 -> 0xF8000000; slt(-1,1)=1, sltu(-1,1)=0.
- addiu $2,$0,10 then syscall (0x0000000C) -> no write, reg_wr_top=0, PC+4; bench terminates.
